// File: rtl/ram_iface_responder.sv
// RAM-side responder for the cache<->RAM FIFO link.
// Pops request words (header + write data) from the request FIFO, runs
// BURST_LEN-word writes or reads on a synchronous single-port RAM, and pushes
// read data, or a single zero write-ack word, into the response FIFO.
module ram_iface_responder #(
  parameter int ADDR_SIZE  = 13,
  parameter int WORD_WIDTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int BURST_LOG2 = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_empty,
  input  logic                            req_avalid,
  input  logic                            req_rnw,
  input  logic [ADDR_SIZE-1:0]            req_addr,
  input  logic [WORD_WIDTH-1:0]           req_wdata,
  output logic                            req_rd,
  input  logic                            rsp_full,
  output logic                            rsp_wr,
  output logic [WORD_WIDTH-1:0]           rsp_wdata,
  output logic [ADDR_SIZE+BURST_LOG2-1:0] mem_addr,
  output logic                            mem_we,
  output logic                            mem_re,
  output logic [WORD_WIDTH-1:0]           mem_wdata,
  input  logic [WORD_WIDTH-1:0]           mem_rdata,
  output logic                            busy,
  output logic                            err
);

  typedef enum logic [2:0] {
    IDLE, WR_COLLECT, WR_ACK, RD_ISSUE, RD_WAIT, RD_CAPT
  } state_t;

  localparam logic [BURST_LOG2-1:0] IDX_LAST = BURST_LOG2'(BURST_LEN - 1);
  localparam logic [BURST_LOG2-1:0] IDX_ONE  = BURST_LOG2'(1);

  state_t                 state, state_nx;
  logic [ADDR_SIZE-1:0]   line;
  logic [BURST_LOG2-1:0]  idx;
  logic                   idx_last;
  logic                   rsp_ok;

  assign idx_last = (idx == IDX_LAST);
  // The full flag lags our own push by a cycle, so a push in flight counts as full.
  assign rsp_ok   = !rsp_full && !rsp_wr;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:
        if (!req_empty && req_avalid) state_nx = req_rnw ? RD_ISSUE : WR_COLLECT;
      WR_COLLECT:
        if (!req_empty) begin
          if (req_avalid)    state_nx = IDLE;     // truncated burst, header served from IDLE
          else if (idx_last) state_nx = WR_ACK;
        end
      WR_ACK:   if (rsp_ok) state_nx = IDLE;
      RD_ISSUE: if (rsp_ok) state_nx = RD_WAIT;
      RD_WAIT:  state_nx = RD_CAPT;
      RD_CAPT:  state_nx = idx_last ? IDLE : RD_ISSUE;
      default:  state_nx = IDLE;
    endcase
  end

  // Combinational outputs: pop strobe and busy flag
  always_comb begin
    req_rd = 1'b0;
    case (state)
      IDLE:       req_rd = !req_empty;
      WR_COLLECT: req_rd = !req_empty && !req_avalid;
      default:    req_rd = 1'b0;
    endcase
    busy = (state != IDLE);
  end

  // Registered datapath: line/idx tracking, RAM strobes and response push
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line      <= '0;
      idx       <= '0;
      rsp_wr    <= 1'b0;
      rsp_wdata <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      rsp_wr <= 1'b0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE:
          if (!req_empty) begin
            if (!req_avalid) begin
              err <= 1'b1;                      // orphan data word is discarded
            end else begin
              line <= req_addr;
              if (!req_rnw) begin
                mem_addr  <= {req_addr, {BURST_LOG2{1'b0}}};
                mem_wdata <= req_wdata;
                mem_we    <= 1'b1;
                idx       <= IDX_ONE;
              end else begin
                idx <= '0;
              end
            end
          end
        WR_COLLECT:
          if (!req_empty) begin
            if (req_avalid) begin
              err <= 1'b1;
            end else begin
              mem_addr  <= {line, idx};
              mem_wdata <= req_wdata;
              mem_we    <= 1'b1;
              if (!idx_last) idx <= idx + IDX_ONE;
            end
          end
        WR_ACK:
          if (rsp_ok) begin
            rsp_wr    <= 1'b1;
            rsp_wdata <= '0;
          end
        RD_ISSUE:
          if (rsp_ok) begin
            mem_addr <= {line, idx};
            mem_re   <= 1'b1;
          end
        RD_CAPT: begin
          rsp_wdata <= mem_rdata;
          rsp_wr    <= 1'b1;
          idx       <= idx_last ? '0 : idx + IDX_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_iface_responder.sv
// Bench for ram_iface_responder: request FIFO and RAM models, a line-level
// scoreboard of expected RAM writes / responses / error pulses, and directed tests.
module tb_ram_iface_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_empty, req_avalid, req_rnw, req_rd;
  logic [12:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_full = 1'b0;
  logic        rsp_wr;
  logic [15:0] rsp_wdata;
  logic [14:0] mem_addr;
  logic        mem_we, mem_re;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        busy, err;

  ram_iface_responder #(.ADDR_SIZE(13), .WORD_WIDTH(16), .BURST_LEN(4), .BURST_LOG2(2)) dut (
    .clk(clk), .reset(reset),
    .req_empty(req_empty), .req_avalid(req_avalid), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_full(rsp_full), .rsp_wr(rsp_wr), .rsp_wdata(rsp_wdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- check bookkeeping ----------------
  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- request FIFO (FWFT) ----------------
  logic        rq_av  [0:255];
  logic        rq_rnw [0:255];
  logic [12:0] rq_addr[0:255];
  logic [15:0] rq_data[0:255];
  logic [7:0]  rq_head = '0;
  logic [7:0]  rq_tail = '0;

  assign req_empty  = (rq_head == rq_tail);
  assign req_avalid = rq_av[rq_head];
  assign req_rnw    = rq_rnw[rq_head];
  assign req_addr   = rq_addr[rq_head];
  assign req_wdata  = rq_data[rq_head];

  int cyc = 0;
  int pop_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_rd && !req_empty) begin
      if (req_avalid) pop_cyc <= cyc;
      rq_head <= rq_head + 8'd1;
    end
  end

  task automatic push_hdr(input logic rnw, input logic [12:0] a, input logic [15:0] d);
    rq_av[rq_tail] = 1'b1; rq_rnw[rq_tail] = rnw; rq_addr[rq_tail] = a; rq_data[rq_tail] = d;
    rq_tail = rq_tail + 8'd1;
  endtask

  task automatic push_data(input logic [15:0] d);
    rq_av[rq_tail] = 1'b0; rq_rnw[rq_tail] = 1'b0; rq_addr[rq_tail] = '0; rq_data[rq_tail] = d;
    rq_tail = rq_tail + 8'd1;
  endtask

  // ---------------- synchronous RAM ----------------
  logic [15:0] ram[0:32767];
  logic        pl_en = 1'b0;
  logic [14:0] pl_addr = '0;
  logic [15:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en)  ram[pl_addr] <= pl_data;
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [14:0] addr; logic [15:0] data; } wr_t;
  wr_t         exp_w[$];
  logic [15:0] exp_r[$];
  int          exp_err = 0;
  logic [15:0] shadow[0:32767];

  task automatic preload(input logic [14:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d; shadow[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic model_word_write(input logic [14:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    exp_w.push_back(w);
    shadow[a] = d;
  endtask

  // A full line write: four RAM writes at line*4+i, then a zero ack word.
  task automatic model_line_write(input logic [12:0] line, input logic [15:0] d0,
                                  input logic [15:0] d1, input logic [15:0] d2,
                                  input logic [15:0] d3);
    model_word_write({line, 2'd0}, d0);
    model_word_write({line, 2'd1}, d1);
    model_word_write({line, 2'd2}, d2);
    model_word_write({line, 2'd3}, d3);
    exp_r.push_back(16'h0000);
  endtask

  // A line read returns the line's current contents in word order.
  task automatic model_line_read(input logic [12:0] line);
    for (int i = 0; i < 4; i++) exp_r.push_back(shadow[{line, 2'(i)}]);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        if (exp_w.size() == 0) chk("unexpected_mem_we", 32'(mem_addr), 32'hFFFF_FFFF);
        else begin
          wr_t e;
          e = exp_w.pop_front();
          chk("we_addr", 32'(mem_addr), 32'(e.addr));
          chk("we_data", 32'(mem_wdata), 32'(e.data));
        end
      end
      if (rsp_wr) begin
        if (exp_r.size() == 0) chk("unexpected_rsp_wr", 32'(rsp_wdata), 32'hFFFF_FFFF);
        else chk("rsp_data", 32'(rsp_wdata), 32'(exp_r.pop_front()));
      end
      if (err) begin
        if (exp_err == 0) chk("unexpected_err", 32'd1, 32'd0);
        else begin exp_err--; chk("err_pulse", 32'd1, 32'd1); end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_done(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (exp_w.size() == 0 && exp_r.size() == 0 && exp_err == 0 && !busy && req_empty) ok = 1'b1;
    end
    repeat (4) @(negedge clk);
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic wait_sig(input bit sel_rsp, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (sel_rsp ? rsp_wr : mem_we) ok = 1'b1;
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_req_rd"}, 32'(req_rd), 0);
    chk({nm, "_rsp_wr"}, 32'(rsp_wr), 0);
    chk({nm, "_rsp_wdata"}, 32'(rsp_wdata), 0);
    chk({nm, "_mem_addr"}, 32'(mem_addr), 0);
    chk({nm, "_mem_we"}, 32'(mem_we), 0);
    chk({nm, "_mem_re"}, 32'(mem_re), 0);
    chk({nm, "_mem_wdata"}, 32'(mem_wdata), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_err"}, 32'(err), 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    bit ok;
    int cnt;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Full write burst to line 0x012 -> RAM 0x048..0x04B, then ack.
    model_line_write(13'h012, 16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3);
    push_hdr(1'b0, 13'h012, 16'hA0A0);
    push_data(16'hB1B1); push_data(16'hC2C2); push_data(16'hD3D3);
    wait_sig(1'b0, ok);
    chk("wr_first_seen", 32'(ok), 1);
    chk("wr_latency", 32'(cyc - pop_cyc), 1);
    chk("wr_first_addr", 32'(mem_addr), 32'h048);
    wait_done("wr_done");
    chk("ram_048", 32'(ram[15'h048]), 32'hA0A0);
    chk("ram_04B", 32'(ram[15'h04B]), 32'hD3D3);

    // Read line 0x012 after preloading 1..4.
    for (int i = 0; i < 4; i++) preload(15'h048 + 15'(i), 16'(i + 1));
    model_line_read(13'h012);
    push_hdr(1'b1, 13'h012, 16'h0000);
    wait_sig(1'b1, ok);
    chk("rd_first_seen", 32'(ok), 1);
    chk("rd_latency", 32'(cyc - pop_cyc), 4);
    chk("rd_first_word", 32'(rsp_wdata), 32'h0001);
    wait_done("rd_done");

    // Backpressure: response FIFO full for 10 cycles stalls the read entirely.
    rsp_full = 1'b1;
    model_line_read(13'h012);
    push_hdr(1'b1, 13'h012, 16'h0000);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_re || rsp_wr) cnt++;
    end
    chk("bp_quiet", 32'(cnt), 0);
    chk("bp_busy", 32'(busy), 1);
    rsp_full = 1'b0;
    wait_done("bp_done");

    // Write with gaps in the request stream.
    model_line_write(13'h020, 16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3);
    push_hdr(1'b0, 13'h020, 16'hA0A0);
    repeat (3) @(negedge clk);
    push_data(16'hB1B1);
    repeat (2) @(negedge clk);
    push_data(16'hC2C2);
    repeat (4) @(negedge clk);
    push_data(16'hD3D3);
    wait_done("gap_done");
    chk("ram_080", 32'(ram[15'h080]), 32'hA0A0);
    chk("ram_083", 32'(ram[15'h083]), 32'hD3D3);

    // Orphan data word in IDLE: popped, one err pulse, nothing else.
    exp_err++;
    push_data(16'h5555);
    wait_done("orphan_done");

    // Header after two write words: truncated burst, err, next header served.
    exp_err++;
    model_word_write(15'h028, 16'h1111);
    model_word_write(15'h029, 16'h2222);
    model_line_write(13'h00B, 16'h3333, 16'h4444, 16'h5555, 16'h6666);
    push_hdr(1'b0, 13'h00A, 16'h1111);
    push_data(16'h2222);
    push_hdr(1'b0, 13'h00B, 16'h3333);
    push_data(16'h4444); push_data(16'h5555); push_data(16'h6666);
    wait_done("trunc_done");
    chk("ram_029", 32'(ram[15'h029]), 32'h2222);
    chk("ram_02C", 32'(ram[15'h02C]), 32'h3333);

    // Reset in the middle of a read burst.
    model_line_read(13'h012);
    push_hdr(1'b1, 13'h012, 16'h0000);
    wait_sig(1'b1, ok);
    chk("rst_rd_first_seen", 32'(ok), 1);
    #2 reset = 1'b1;
    #1 chk_all_zero("midreset");
    exp_r.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Normal operation after reset: write then read back line 0x030.
    model_line_write(13'h030, 16'h0F0F, 16'h1E1E, 16'h2D2D, 16'h3C3C);
    push_hdr(1'b0, 13'h030, 16'h0F0F);
    push_data(16'h1E1E); push_data(16'h2D2D); push_data(16'h3C3C);
    wait_done("post_rst_wr");
    model_line_read(13'h030);
    push_hdr(1'b1, 13'h030, 16'h0000);
    wait_done("post_rst_rd");
    chk("ram_0C2", 32'(ram[15'h0C2]), 32'h2D2D);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
